// File: rtl/axis_image_header_sequencer.sv
// axis_image_header_sequencer: per job, emits one config header beat and then cfg_beats_1+1 image beats, repeated cfg_iters_1+1 times.
// Latency: the header appears one cycle after the cfg handshake and image beats pass straight through; IMAGE_SEQ_OUT_REG_EN adds one cycle.
// Backpressure: in PASS, m_axis_tready drives s_axis_tready directly; with IMAGE_SEQ_OUT_REG_EN a 2-entry skid buffer separates the two.
module axis_image_header_sequencer #(
   parameter int WORD_WIDTH         = 8,
   parameter int WORDS              = 8,
   parameter int KERNEL_H_MAX       = 3,
   parameter int BITS_BEATS         = 20,
   parameter int BITS_ITERS         = 16,
   parameter int I_IMAGE_IS_NOT_MAX = 0,
   parameter int I_IMAGE_IS_MAX     = 1,
   parameter int I_IMAGE_IS_LRELU   = 2,
   parameter int I_IMAGE_KERNEL_H_1 = 3
) (
   input  logic                            aclk,
   input  logic                            areset,
   input  logic                            cfg_valid,
   output logic                            cfg_ready,
   input  logic                            cfg_is_max,
   input  logic                            cfg_is_lrelu,
   input  logic [$clog2(KERNEL_H_MAX)-1:0] cfg_kernel_h_1,
   input  logic [BITS_BEATS-1:0]           cfg_beats_1,
   input  logic [BITS_ITERS-1:0]           cfg_iters_1,
   input  logic                            s_axis_tvalid,
   output logic                            s_axis_tready,
   input  logic [WORD_WIDTH*WORDS-1:0]     s_axis_tdata,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic [WORD_WIDTH*WORDS-1:0]     m_axis_tdata,
   output logic [WORD_WIDTH*WORDS/8-1:0]   m_axis_tkeep,
   output logic                            m_axis_tlast,
   output logic                            busy,
   output logic                            done,
   output logic                            cfg_err
);

   localparam int KW = $clog2(KERNEL_H_MAX);
   localparam int DW = WORD_WIDTH * WORDS;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HEADER = 2'd1,
      PASS   = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t                state_q, state_d;

   // Latched job configuration
   logic                  is_max_q;
   logic                  is_lrelu_q;
   logic [KW-1:0]         kernel_h_1_q;
   logic [BITS_BEATS-1:0] beats_1_q;
   logic [BITS_ITERS-1:0] iters_1_q;
   logic                  load_cfg;

   // Framing counters
   logic [BITS_BEATS-1:0] beat_cnt_q, beat_cnt_d;
   logic [BITS_ITERS-1:0] iter_cnt_q, iter_cnt_d;

   logic                  cfg_err_q, cfg_err_d;
   logic                  cfg_illegal;
   logic                  cfg_rdy_c;
   logic                  s_rdy_c;
   logic                  done_c;

   // Internal sequenced stream, before the optional output stage
   logic                  seq_vld;
   logic                  seq_rdy;
   logic                  seq_last;
   logic [DW-1:0]         seq_dat;
   logic [DW-1:0]         hdr_dat;

`ifdef IMAGE_SEQ_OUT_REG_EN
   logic                  out_empty;
`endif

   // Kernel height minus one must be even (odd kernel heights) and inside the supported range
   assign cfg_illegal = cfg_kernel_h_1[0] || (int'(cfg_kernel_h_1) >= KERNEL_H_MAX);

   // Header beat assembled from the latched job flags; unused words stay zero
   always_comb begin
      hdr_dat = '0;
      hdr_dat[I_IMAGE_IS_NOT_MAX*WORD_WIDTH +: WORD_WIDTH] = {{(WORD_WIDTH-1){1'b0}}, ~is_max_q};
      hdr_dat[I_IMAGE_IS_MAX*WORD_WIDTH     +: WORD_WIDTH] = {{(WORD_WIDTH-1){1'b0}}, is_max_q};
      hdr_dat[I_IMAGE_IS_LRELU*WORD_WIDTH   +: WORD_WIDTH] = {{(WORD_WIDTH-1){1'b0}}, is_lrelu_q};
      hdr_dat[I_IMAGE_KERNEL_H_1*WORD_WIDTH +: WORD_WIDTH] = {{(WORD_WIDTH-KW){1'b0}}, kernel_h_1_q};
   end

   // Next-state, counter updates and stream steering for each state
   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      iter_cnt_d = iter_cnt_q;
      cfg_err_d  = 1'b0;
      load_cfg   = 1'b0;
      cfg_rdy_c  = 1'b0;
      s_rdy_c    = 1'b0;
      done_c     = 1'b0;
      seq_vld    = 1'b0;
      seq_last   = 1'b0;
      seq_dat    = '0;
      case (state_q)
         IDLE: begin
            cfg_rdy_c = 1'b1;
            if (cfg_valid) begin
               if (cfg_illegal) begin
                  cfg_err_d = 1'b1;
               end else begin
                  load_cfg   = 1'b1;
                  iter_cnt_d = '0;
                  state_d    = HEADER;
               end
            end
         end
         HEADER: begin
            seq_vld = 1'b1;
            seq_dat = hdr_dat;
            if (seq_rdy) begin
               beat_cnt_d = '0;
               state_d    = PASS;
            end
         end
         PASS: begin
            seq_vld  = s_axis_tvalid;
            s_rdy_c  = seq_rdy;
            seq_dat  = s_axis_tdata;
            seq_last = (beat_cnt_q == beats_1_q);
            if (s_axis_tvalid && seq_rdy) begin
               beat_cnt_d = beat_cnt_q + BITS_BEATS'(1);
               if (seq_last) begin
                  if (iter_cnt_q == iters_1_q) begin
                     state_d = DONE;
                  end else begin
                     iter_cnt_d = iter_cnt_q + BITS_ITERS'(1);
                     state_d    = HEADER;
                  end
               end
            end
         end
         DONE: begin
`ifdef IMAGE_SEQ_OUT_REG_EN
            // Completion is reported only once the last beat has drained downstream
            if (out_empty) begin
               done_c  = 1'b1;
               state_d = IDLE;
            end
`else
            done_c  = 1'b1;
            state_d = IDLE;
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, counters and the error pulse register
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q    <= IDLE;
         beat_cnt_q <= '0;
         iter_cnt_q <= '0;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         iter_cnt_q <= iter_cnt_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   // Job configuration is captured only when a legal config is accepted
   always_ff @(posedge aclk) begin
      if (areset) begin
         is_max_q     <= 1'b0;
         is_lrelu_q   <= 1'b0;
         kernel_h_1_q <= '0;
         beats_1_q    <= '0;
         iters_1_q    <= '0;
      end else if (load_cfg) begin
         is_max_q     <= cfg_is_max;
         is_lrelu_q   <= cfg_is_lrelu;
         kernel_h_1_q <= cfg_kernel_h_1;
         beats_1_q    <= cfg_beats_1;
         iters_1_q    <= cfg_iters_1;
      end
   end

`ifdef IMAGE_SEQ_OUT_REG_EN
   // Two-entry skid buffer: ready toward the sequencer depends only on occupancy
   logic [DW:0] skid_mem [2];
   logic        skid_wr_q;
   logic        skid_rd_q;
   logic [1:0]  skid_cnt_q;
   logic        skid_push;
   logic        skid_pop;

   assign seq_rdy   = (skid_cnt_q != 2'd2);
   assign out_empty = (skid_cnt_q == 2'd0);
   assign skid_push = seq_vld && seq_rdy;
   assign skid_pop  = !out_empty && m_axis_tready;

   // Pointers and occupancy; reset discards any buffered beats
   always_ff @(posedge aclk) begin
      if (areset) begin
         skid_wr_q  <= 1'b0;
         skid_rd_q  <= 1'b0;
         skid_cnt_q <= 2'd0;
      end else begin
         if (skid_push) skid_wr_q <= ~skid_wr_q;
         if (skid_pop)  skid_rd_q <= ~skid_rd_q;
         skid_cnt_q <= skid_cnt_q + 2'(skid_push) - 2'(skid_pop);
      end
   end

   // Beat storage; contents are qualified by occupancy so no reset is needed
   always_ff @(posedge aclk) begin
      if (skid_push) skid_mem[skid_wr_q] <= {seq_last, seq_dat};
   end

   assign m_axis_tvalid = !out_empty && !areset;
   assign m_axis_tdata  = skid_mem[skid_rd_q][DW-1:0];
   assign m_axis_tlast  = skid_mem[skid_rd_q][DW] && m_axis_tvalid;
`else
   assign seq_rdy       = m_axis_tready;
   assign m_axis_tvalid = seq_vld && !areset;
   assign m_axis_tdata  = seq_dat;
   assign m_axis_tlast  = seq_last && !areset;
`endif

   // Handshake and status outputs are forced to idle values while reset is held
   assign m_axis_tkeep  = '1;
   assign s_axis_tready = s_rdy_c && !areset;
   assign cfg_ready     = cfg_rdy_c && !areset;
   assign busy          = (state_q != IDLE) && !areset;
   assign done          = done_c && !areset;
   assign cfg_err       = cfg_err_q;

endmodule
